uart_rx_param: RTL and testbench

- Parametrised, oversampling UART receiver. Next generation of the team's fixed 8-bit receiver.
- Adds configurable data width, parity and stop bits, majority-vote bit sampling, false-start rejection, and error flags.
- Adds a valid/ready output handshake with overrun detection.
- Sits between the asynchronous rx pin and the byte-consuming logic (FIFO or bus bridge). Single clock domain; the baud tick is generated internally.

---
 rtl/uart_rx_param.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable width, parity and stop bits.
// Majority-vote sampling, false-start rejection, valid/ready output with overrun.
module uart_rx_param #(
    parameter int BAUD_DIV   = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TMAX = TW'(BAUD_DIV - 1);
    localparam logic [OW-1:0] OMAX = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] S0   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] S1   = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] S2   = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);
    localparam logic          SMAX = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic                 rx_d;
    logic [TW-1:0]        tick_cnt;
    logic [OW-1:0]        os_cnt;
    logic                 smp0;
    logic                 smp1;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 pe_p;
    logic                 fe_p;
    logic                 done;

    logic tick;
    logic fall;
    logic arm;
    logic resolve;
    logic bitv;
    logic par_exp;

    assign tick    = (tick_cnt == TMAX);
    assign fall    = rx_d & ~rx_s;
    assign arm     = (state == IDLE) && fall;
    assign resolve = tick && (os_cnt == S2);
    assign bitv    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign par_exp = (PARITY == 1) ? ~(^shreg) : (^shreg);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Bit timing restarts from the detected start edge
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
        end else if (tick) begin
            tick_cnt <= '0;
            os_cnt   <= (os_cnt == OMAX) ? '0 : os_cnt + OW'(1);
            if (os_cnt == S0) smp0 <= rx_s;
            if (os_cnt == S1) smp1 <= rx_s;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            pe_p     <= 1'b0;
            fe_p     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (resolve) begin
                        if (bitv) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            pe_p    <= 1'b0;
                            fe_p    <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (resolve) begin
                        shreg   <= {bitv, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BMAX) begin
                            state    <= (PARITY != 0) ? PAR : STOP;
                            stop_cnt <= 1'b0;
                        end
                    end
                end
                PAR: begin
                    if (resolve) begin
                        if (bitv != par_exp) pe_p <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (resolve) begin
                        if (!bitv) fe_p <= 1'b1;
                        if (stop_cnt == SMAX) begin
                            done <= 1'b1;
                            if (fe_p || !bitv) begin
                                state <= WAIT_IDLE;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A finished frame only overwrites the output if it is free or being taken
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done && (!valid || ready)) begin
                data       <= shreg;
                parity_err <= pe_p;
                frame_err  <= fe_p;
                valid      <= 1'b1;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (valid && ready) begin
                valid      <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one 8N1 receiver and one 8E1 receiver.
// Frames are driven bit by bit at 64 clks per bit.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       pe0, pe1, fe0, fe1;
    logic       ovr0, ovr1, busy0, busy1;

    int total = 0;
    int bad = 0;

    int n0 = 0, n1 = 0, ov0 = 0, ov1 = 0;
    logic [7:0] d0 = 0, d1 = 0;
    logic pe0c = 0, fe0c = 0, pe1c = 0, fe1c = 0;
    logic arm22 = 1'b0;
    logic seen22 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx0), .ready(ready),
        .data(data0), .valid(valid0), .parity_err(pe0),
        .frame_err(fe0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_param #(
        .BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1)
    ) dut_p (
        .clk(clk), .rst(rst), .rx(rx1), .ready(ready),
        .data(data1), .valid(valid1), .parity_err(pe1),
        .frame_err(fe1), .overrun(ovr1), .busy(busy1)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (valid0 && ready) begin
                n0++; d0 = data0; pe0c = pe0; fe0c = fe0;
            end
            if (valid1 && ready) begin
                n1++; d1 = data1; pe1c = pe1; fe1c = fe1;
            end
            if (ovr0) ov0++;
            if (ovr1) ov1++;
            if (arm22 && data0 == 8'h22) seen22 = 1'b1;
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: sim did not finish, want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic setrx(input int w, input logic v);
        if (w == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic send(input int w, input logic [7:0] d, input logic pb,
                        input logic sv, input int hold);
        logic [10:0] f;
        int n;
        if (w == 1) begin
            f = {sv, pb, d, 1'b0};
            n = 11;
        end else begin
            f = {1'b0, sv, d, 1'b0};
            n = 10;
        end
        for (int i = 0; i < n; i++) begin
            setrx(w, f[i]);
            repeat (64) @(negedge clk);
        end
        if (hold > 0) repeat (hold) @(negedge clk);
        setrx(w, 1'b1);
        repeat (16) @(negedge clk);
    endtask

    typedef struct {
        int         w;
        logic [7:0] d;
        logic       pb;
        logic       sv;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    vec_t tv[8];

    initial begin
        int bn, bo, lat, b2;
        logic gone;

        tv[0] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tv[1] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tv[2] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        tv[3] = '{1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tv[4] = '{1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tv[5] = '{1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        tv[6] = '{1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tv[7] = '{1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst data", data0, 0);
        chk("rst valid", valid0, 0);
        chk("rst perr", pe0, 0);
        chk("rst ferr", fe0, 0);
        chk("rst ovr", ovr0, 0);
        chk("rst busy", busy0, 0);
        repeat (20) @(negedge clk);

        lat = -1;
        fork
            send(0, 8'hA5, 1'b0, 1'b1, 0);
            begin
                for (int c = 0; c < 800; c++) begin
                    @(negedge clk);
                    if (valid0 && lat < 0) lat = c + 1;
                end
            end
        join
        chk("a5 lat ok", (lat >= 612 && lat <= 628), 1);
        chk("a5 cnt", n0, 1);
        chk("a5 data", d0, 8'hA5);
        chk("a5 perr", pe0c, 0);
        chk("a5 ferr", fe0c, 0);
        chk("a5 ovr", ov0, 0);
        chk("a5 pulse", valid0, 0);

        for (int i = 0; i < 8; i++) begin
            bn = (tv[i].w == 0) ? n0 : n1;
            bo = ov0 + ov1;
            send(tv[i].w, tv[i].d, tv[i].pb, tv[i].sv, 0);
            chk($sformatf("v%0d cnt", i),
                ((tv[i].w == 0) ? n0 : n1) - bn, 1);
            chk($sformatf("v%0d data", i),
                (tv[i].w == 0) ? d0 : d1, tv[i].ed);
            chk($sformatf("v%0d perr", i),
                (tv[i].w == 0) ? pe0c : pe1c, tv[i].epe);
            chk($sformatf("v%0d ferr", i),
                (tv[i].w == 0) ? fe0c : fe1c, tv[i].efe);
            chk($sformatf("v%0d ovr", i), ov0 + ov1 - bo, 0);
        end

        bn = n0;
        rx0 = 1'b0;
        repeat (8) @(negedge clk);
        rx0 = 1'b1;
        chk("fs busy", busy0, 1);
        gone = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy0) gone = 1'b1;
        end
        chk("fs idle", gone, 1);
        repeat (700) @(negedge clk);
        chk("fs novalid", n0 - bn, 0);

        bn = n0;
        fork
            send(0, 8'h55, 1'b0, 1'b0, 200);
            begin
                repeat (740) @(negedge clk);
                chk("brk wait", busy0, 1);
                chk("brk cnt", n0 - bn, 1);
            end
        join
        chk("brk idle", busy0, 0);
        chk("brk data", d0, 8'h55);
        chk("brk ferr", fe0c, 1);
        send(0, 8'h12, 1'b0, 1'b1, 0);
        chk("brk2 cnt", n0 - bn, 2);
        chk("brk2 data", d0, 8'h12);
        chk("brk2 ferr", fe0c, 0);

        bn = n0;
        bo = ov0;
        b2 = n1;
        ready = 1'b0;
        arm22 = 1'b1;
        send(0, 8'h11, 1'b0, 1'b1, 0);
        chk("ovr hold v", valid0, 1);
        chk("ovr hold d", data0, 8'h11);
        send(0, 8'h22, 1'b0, 1'b1, 0);
        chk("ovr pulse", ov0 - bo, 1);
        chk("ovr keep v", valid0, 1);
        chk("ovr keep d", data0, 8'h11);
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr drop", valid0, 0);
        chk("ovr cnt", n0 - bn, 1);
        chk("ovr take", d0, 8'h11);
        chk("ovr no22", seen22, 0);
        arm22 = 1'b0;
        chk("ovr other", n1 - b2, 0);

        bn = n0;
        rx0 = 1'b0;
        repeat (128) @(negedge clk);
        rx0 = 1'b1;
        repeat (128) @(negedge clk);
        repeat (32) @(negedge clk);
        chk("mid busy", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid outs", {data0, valid0, pe0, fe0, ovr0}, 0);
        chk("mid busy0", busy0, 0);
        repeat (1000) @(negedge clk);
        chk("mid novalid", n0 - bn, 0);
        send(0, 8'h81, 1'b0, 1'b1, 0);
        chk("post cnt", n0 - bn, 1);
        chk("post data", d0, 8'h81);
        chk("post ferr", fe0c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
